// File: rtl/core_scheduler.sv
// Per-core control FSM: broadcasts core_state to the datapath, owns current_pc,
// commits the lowest active thread's next_pc each instruction and flags divergence.
module core_scheduler #(
  parameter int THREADS        = 4,
  parameter int PROG_ADDR_BITS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [THREADS-1:0]                  thread_enable,
  input  logic                                fetch_valid,
  input  logic                                dec_ret,
  input  logic [THREADS-1:0]                  lsu_busy,
  input  logic [THREADS*PROG_ADDR_BITS-1:0]   next_pc,
  output logic [2:0]                          core_state,
  output logic [PROG_ADDR_BITS-1:0]           current_pc,
  output logic                                fetch_req,
  output logic                                done,
  output logic                                diverged,
  output logic [15:0]                         retired
);

  // Encoding is fixed: the PC units decode EXECUTE/UPDATE directly from core_state.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t                    state, state_next;
  logic [THREADS-1:0]        thread_mask;
  logic [PROG_ADDR_BITS-1:0] sel_pc;
  logic                      sel_found;
  logic                      pc_mismatch;

  // Lowest-index active thread supplies the committed PC; any other active
  // thread disagreeing with it is divergence.
  always_comb begin
    sel_pc      = '0;
    sel_found   = 1'b0;
    pc_mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_mask[i] && !sel_found) begin
        sel_pc    = next_pc[i*PROG_ADDR_BITS +: PROG_ADDR_BITS];
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < THREADS; i++) begin
      if (thread_mask[i] && (next_pc[i*PROG_ADDR_BITS +: PROG_ADDR_BITS] != sel_pc))
        pc_mismatch = 1'b1;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (start) state_next = (thread_enable == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetch_valid) state_next = S_DECODE;
      S_DECODE:  state_next = S_REQUEST;
      S_REQUEST: state_next = S_WAIT;
      S_WAIT:    if ((lsu_busy & thread_mask) == '0) state_next = S_EXECUTE;
      S_EXECUTE: state_next = S_UPDATE;
      S_UPDATE:  state_next = dec_ret ? S_DONE : S_FETCH;
      S_DONE:    state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      thread_mask <= '0;
      current_pc  <= '0;
      diverged    <= 1'b0;
      retired     <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        thread_mask <= thread_enable;
        current_pc  <= '0;
        retired     <= '0;
        diverged    <= 1'b0;
      end
      if (state == S_UPDATE) begin
        if (pc_mismatch) diverged <= 1'b1;
        if (!dec_ret) begin
          current_pc <= sel_pc;
          if (retired != 16'hFFFF) retired <= retired + 16'd1;
        end
      end
    end
  end

  assign core_state = state;
  assign fetch_req  = (state == S_FETCH);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: straight-line, branch, stalls, divergence,
// zero mask, reset mid-WAIT and PC wrap, with hand-computed expectations.
module tb_core_scheduler;

  localparam int THREADS = 4;
  localparam int PAB     = 8;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_FETCH  = 3'b001;
  localparam logic [2:0] ST_WAIT   = 3'b100;
  localparam logic [2:0] ST_UPDATE = 3'b110;
  localparam logic [2:0] ST_DONE   = 3'b111;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [THREADS-1:0]       thread_enable;
  logic                     fetch_valid;
  logic                     dec_ret;
  logic [THREADS-1:0]       lsu_busy;
  logic [THREADS*PAB-1:0]   next_pc;
  logic [2:0]               core_state;
  logic [PAB-1:0]           current_pc;
  logic                     fetch_req;
  logic                     done;
  logic                     diverged;
  logic [15:0]              retired;

  int total = 0;
  int bad   = 0;
  int cyc;

  core_scheduler #(.THREADS(THREADS), .PROG_ADDR_BITS(PAB)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_enable(thread_enable),
    .fetch_valid(fetch_valid), .dec_ret(dec_ret), .lsu_busy(lsu_busy),
    .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
    .fetch_req(fetch_req), .done(done), .diverged(diverged), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; lsu_busy = '0; dec_ret = 1'b0; fetch_valid = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_block(input logic [THREADS-1:0] mask);
    thread_enable = mask; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH through the edge leaving UPDATE; returns its period.
  task automatic run_instr(input logic [31:0] npc, input logic ret, input int fv_low,
                           input int busy_n, input logic [THREADS-1:0] busy, output int n);
    logic [2:0] st;
    int fl, bl;
    bit fin;
    fl = fv_low; bl = busy_n; n = 0; fin = 0;
    next_pc = npc; dec_ret = ret;
    for (int g = 0; g < 200 && !fin; g++) begin
      st = core_state;
      fetch_valid = !(st == ST_FETCH && fl > 0);
      if (st == ST_FETCH && fl > 0) fl--;
      lsu_busy = (st == ST_WAIT && bl > 0) ? busy : '0;
      if (st == ST_WAIT && bl > 0) bl--;
      tick();
      n++;
      if (st == ST_UPDATE) fin = 1;
    end
    lsu_busy = '0; fetch_valid = 1'b1;
    if (!fin) check("instr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    thread_enable = '0; next_pc = '0;
    do_reset();
    check("rst_state", core_state, ST_IDLE);
    check("rst_pc", current_pc, 0);
    check("rst_fetch_req", fetch_req, 0);
    check("rst_done", done, 0);
    check("rst_diverged", diverged, 0);
    check("rst_retired", retired, 0);

    // Straight-line: start with fetch_valid high lands in FETCH, not DECODE.
    fetch_valid = 1'b1;
    start_block(4'b1111);
    for (int k = 0; k < 4; k++) begin
      next_pc = {4{8'(k + 1)}};
      dec_ret = (k == 3);
      for (int s = 1; s <= 6; s++) begin
        check("sl_state", core_state, s);
        check("sl_pc", current_pc, k);
        check("sl_fetch_req", fetch_req, (s == 1));
        tick();
      end
    end
    // 1 start edge + 24 instruction edges = cycle 25.
    check("sl_done_state", core_state, ST_DONE);
    check("sl_done", done, 1);
    check("sl_done_pc", current_pc, 3);
    check("sl_retired", retired, 3);
    check("sl_diverged", diverged, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("done_ignores_start", core_state, ST_DONE);

    // Branch to 0x10 at pc 2, then fetch and LSU stalls.
    do_reset();
    start_block(4'b1111);
    run_instr({4{8'h01}}, 0, 0, 0, '0, cyc);
    run_instr({4{8'h02}}, 0, 0, 0, '0, cyc);
    check("br_pre_pc", current_pc, 2);
    run_instr({4{8'h10}}, 0, 0, 0, '0, cyc);
    check("br_pc", current_pc, 8'h10);
    check("br_diverged", diverged, 0);
    check("br_period", cyc, 6);
    run_instr({4{8'h11}}, 0, 3, 0, '0, cyc);
    check("fetch_stall_period", cyc, 9);
    run_instr({4{8'h12}}, 0, 0, 5, 4'b0010, cyc);
    check("lsu_stall_period", cyc, 11);
    check("stall_pc", current_pc, 8'h12);
    check("stall_retired", retired, 5);

    // Mask 1101: thread 1 busy and its odd next_pc are both ignored.
    do_reset();
    start_block(4'b1101);
    run_instr({8'h07, 8'h07, 8'hEE, 8'h07}, 0, 0, 5, 4'b0010, cyc);
    check("masked_busy_period", cyc, 6);
    check("masked_pc", current_pc, 8'h07);
    check("masked_no_div", diverged, 0);
    run_instr({8'h08, 8'h08, 8'h08, 8'h08}, 0, 0, 2, 4'b0001, cyc);
    check("busy_t0_period", cyc, 8);

    // Divergence with mask 0110: thread 1 wins, flag is sticky.
    do_reset();
    start_block(4'b0110);
    run_instr({8'hAA, 8'h09, 8'h05, 8'h00}, 0, 0, 0, '0, cyc);
    check("div_pc", current_pc, 8'h05);
    check("div_flag", diverged, 1);
    run_instr({4{8'h06}}, 0, 0, 0, '0, cyc);
    check("div_sticky", diverged, 1);
    check("div_pc2", current_pc, 8'h06);
    run_instr({4{8'h33}}, 1, 0, 0, '0, cyc);
    check("ret_state", core_state, ST_DONE);
    check("ret_pc_unchanged", current_pc, 8'h06);
    check("ret_retired", retired, 2);
    check("ret_div_held", diverged, 1);
    do_reset();
    start_block(4'b1111);
    check("div_cleared", diverged, 0);

    // Zero mask: straight to DONE.
    do_reset();
    start_block(4'b0000);
    check("zero_mask_state", core_state, ST_DONE);
    check("zero_mask_done", done, 1);
    check("zero_mask_retired", retired, 0);

    // Reset while stalled in WAIT.
    do_reset();
    start_block(4'b1111);
    run_instr({4{8'h04}}, 0, 0, 0, '0, cyc);
    lsu_busy = 4'b1111;
    for (int g = 0; g < 20 && core_state != ST_WAIT; g++) tick();
    check("reach_wait", core_state, ST_WAIT);
    tick();
    reset = 1'b1; tick(); reset = 1'b0; lsu_busy = '0;
    check("wrst_state", core_state, ST_IDLE);
    check("wrst_pc", current_pc, 0);
    check("wrst_fetch_req", fetch_req, 0);
    check("wrst_done", done, 0);
    check("wrst_retired", retired, 0);

    // PC wrap: 0xFF then 0x00 committed as-is.
    start_block(4'b1011);
    run_instr({4{8'hFF}}, 0, 0, 0, '0, cyc);
    check("wrap_ff", current_pc, 8'hFF);
    run_instr({4{8'h00}}, 0, 0, 0, '0, cyc);
    check("wrap_00", current_pc, 8'h00);
    check("wrap_retired", retired, 2);
    check("wrap_state", core_state, ST_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
